// File: rtl/noise_pkg.sv
// Shared encodings and short-mode tap helpers for the noise bank.
package noise_pkg;

   localparam logic MODE_LONG  = 1'b0;
   localparam logic MODE_SHORT = 1'b1;

   localparam int unsigned SHORT_TAP_HI = 6;
   localparam int unsigned SHORT_TAP_LO = 5;
   localparam int unsigned SHORT_LEN    = SHORT_TAP_HI + 1;

   // The short sequence lives in the low bits; an all-zero low field is kicked back to life.
   function automatic logic short_feedback(input logic [SHORT_LEN-1:0] low);
      if (low == '0) begin
         return 1'b1;
      end
      return low[SHORT_TAP_HI] ^ low[SHORT_TAP_LO];
   endfunction

endpackage

// File: rtl/noise_lfsr_channel.sv
// One noise channel: LFSR, rate divider and its configuration registers.
module noise_lfsr_channel
   import noise_pkg::*;
#(
   parameter int unsigned LFSR_WIDTH = 16,
   parameter int unsigned OUT_WIDTH  = 10,
   parameter int unsigned DIV_WIDTH  = 8
) (
   input  logic                  audio_tick,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  cfg_wr,
   input  logic [DIV_WIDTH-1:0]  cfg_period,
   input  logic                  cfg_mode,
   input  logic                  cfg_seed_load,
   input  logic [LFSR_WIDTH-1:0] cfg_seed,
   output logic [OUT_WIDTH-1:0]  sample,
   output logic                  valid
);

   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]  period_q, period_d;
   logic                  mode_q, mode_d;
   logic                  valid_q, valid_d;
   logic                  feedback;

   always_comb begin
      if (mode_q == MODE_SHORT) begin
         feedback = short_feedback(lfsr_q[SHORT_LEN-1:0]);
      end else begin
         feedback = lfsr_q[LFSR_WIDTH-1] ^ lfsr_q[LFSR_WIDTH-3] ^
                    lfsr_q[LFSR_WIDTH-4] ^ lfsr_q[LFSR_WIDTH-6];
      end
   end

   // A configuration write pre-empts any step that was due in the same tick.
   always_comb begin
      lfsr_d   = lfsr_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      mode_d   = mode_q;
      valid_d  = 1'b0;
      if (cfg_wr) begin
         period_d = cfg_period;
         mode_d   = cfg_mode;
         cnt_d    = cfg_period;
         if (cfg_seed_load) begin
            lfsr_d = (cfg_seed == '0) ? LFSR_WIDTH'(1) : cfg_seed;
         end
      end else if (enable) begin
         if (cnt_q == '0) begin
            lfsr_d  = {lfsr_q[LFSR_WIDTH-2:0], feedback};
            cnt_d   = period_q;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge audio_tick) begin
      if (reset) begin
         lfsr_q   <= '1;
         cnt_q    <= '0;
         period_q <= '0;
         mode_q   <= MODE_LONG;
         valid_q  <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         valid_q  <= valid_d;
      end
   end

   assign sample = lfsr_q[LFSR_WIDTH-1 -: OUT_WIDTH];
   assign valid  = valid_q;

endmodule

// File: rtl/noise_bank.sv
// Bank of independent LFSR noise channels; this level only decodes writes and packs outputs.
module noise_bank
   import noise_pkg::*;
#(
   parameter int unsigned LFSR_WIDTH = 16,
   parameter int unsigned OUT_WIDTH  = 10,
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned DIV_WIDTH  = 8,
   localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                          audio_tick,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           ch_enable,
   input  logic                          cfg_we,
   input  logic [CH_W-1:0]               cfg_ch,
   input  logic [DIV_WIDTH-1:0]          cfg_period,
   input  logic                          cfg_mode,
   input  logic                          cfg_seed_load,
   input  logic [LFSR_WIDTH-1:0]         cfg_seed,
   output logic [CHANNELS*OUT_WIDTH-1:0] noise_out,
   output logic [CHANNELS-1:0]           noise_valid
);

   logic cfg_hit;

   // Channel indices beyond the populated range are dropped.
   assign cfg_hit = cfg_we && (32'(cfg_ch) < CHANNELS);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic wr;

      assign wr = cfg_hit && (cfg_ch == CH_W'(c));

      noise_lfsr_channel #(
         .LFSR_WIDTH (LFSR_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH),
         .DIV_WIDTH  (DIV_WIDTH)
      ) u_chan (
         .audio_tick    (audio_tick),
         .reset         (reset),
         .enable        (ch_enable[c]),
         .cfg_wr        (wr),
         .cfg_period    (cfg_period),
         .cfg_mode      (cfg_mode),
         .cfg_seed_load (cfg_seed_load),
         .cfg_seed      (cfg_seed),
         .sample        (noise_out[c*OUT_WIDTH +: OUT_WIDTH]),
         .valid         (noise_valid[c])
      );
   end

endmodule

// File: tb/tb_noise_bank.sv
// Scoreboard bench for noise_bank: driver pushes model predictions, monitor compares each tick.
module tb_noise_bank;

   localparam int W  = 16;
   localparam int OW = 10;
   localparam int CH = 6;
   localparam int DW = 8;
   localparam int CW = 3;

   logic              audio_tick = 1'b0;
   logic              reset = 1'b1;
   logic [CH-1:0]     ch_enable = '0;
   logic              cfg_we = 1'b0;
   logic [CW-1:0]     cfg_ch = '0;
   logic [DW-1:0]     cfg_period = '0;
   logic              cfg_mode = 1'b0;
   logic              cfg_seed_load = 1'b0;
   logic [W-1:0]      cfg_seed = '0;
   logic [CH*OW-1:0]  noise_out;
   logic [CH-1:0]     noise_valid;

   noise_bank #(
      .LFSR_WIDTH (W),
      .OUT_WIDTH  (OW),
      .CHANNELS   (CH),
      .DIV_WIDTH  (DW)
   ) dut (
      .audio_tick    (audio_tick),
      .reset         (reset),
      .ch_enable     (ch_enable),
      .cfg_we        (cfg_we),
      .cfg_ch        (cfg_ch),
      .cfg_period    (cfg_period),
      .cfg_mode      (cfg_mode),
      .cfg_seed_load (cfg_seed_load),
      .cfg_seed      (cfg_seed),
      .noise_out     (noise_out),
      .noise_valid   (noise_valid)
   );

   always #5 audio_tick = ~audio_tick;

   typedef struct {
      logic [CH-1:0]    v;
      logic [CH*OW-1:0] o;
      int               ph;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Behavioural model state: one entry per channel.
   logic [W-1:0] m_lfsr [CH];
   int           m_cnt  [CH];
   int           m_per  [CH];
   bit           m_mode [CH];
   int           ch1_steps = 0;
   int           ch1_first_return = -1;

   function automatic logic [W-1:0] next_state(input logic [W-1:0] s, input bit mode);
      bit fb;
      if (mode) fb = (s[6:0] == 7'd0) ? 1'b1 : (s[6] ^ s[5]);
      else      fb = s[W-1] ^ s[W-3] ^ s[W-4] ^ s[W-6];
      return {s[W-2:0], fb};
   endfunction

   task automatic drive(input bit rst, input logic [CH-1:0] en, input bit we,
                        input logic [CW-1:0] ch, input int per, input bit mode,
                        input bit sl, input logic [W-1:0] seed, input int ph);
      exp_t e;
      reset         = rst;
      ch_enable     = en;
      cfg_we        = we;
      cfg_ch        = ch;
      cfg_period    = DW'(per);
      cfg_mode      = mode;
      cfg_seed_load = sl;
      cfg_seed      = seed;
      e.v  = '0;
      e.ph = ph;
      for (int c = 0; c < CH; c++) begin
         if (rst) begin
            m_lfsr[c] = '1;
            m_cnt[c]  = 0;
            m_per[c]  = 0;
            m_mode[c] = 1'b0;
         end else if (we && (int'(ch) == c)) begin
            m_per[c]  = per;
            m_cnt[c]  = per;
            m_mode[c] = mode;
            if (sl) m_lfsr[c] = (seed == '0) ? W'(1) : seed;
         end else if (en[c]) begin
            if (m_cnt[c] == 0) begin
               m_lfsr[c] = next_state(m_lfsr[c], m_mode[c]);
               m_cnt[c]  = m_per[c];
               e.v[c]    = 1'b1;
               if (c == 1) begin
                  ch1_steps++;
                  if (m_lfsr[c] == W'(1) && ch1_first_return < 0) ch1_first_return = ch1_steps;
               end
            end else begin
               m_cnt[c] = m_cnt[c] - 1;
            end
         end
      end
      for (int c = 0; c < CH; c++) e.o[c*OW +: OW] = m_lfsr[c][W-1 -: OW];
      sb.push_back(e);
      @(posedge audio_tick);
      #1;
   endtask

   task automatic idle(input logic [CH-1:0] en, input int n, input int ph);
      for (int i = 0; i < n; i++) drive(1'b0, en, 1'b0, '0, 0, 1'b0, 1'b0, '0, ph);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge audio_tick);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (noise_valid !== e.v) begin
               n_errors++;
               $display("FAIL valid phase %0d: got %b want %b", e.ph, noise_valid, e.v);
            end
            n_checks++;
            if (noise_out !== e.o) begin
               n_errors++;
               $display("FAIL noise_out phase %0d: got %h want %h", e.ph, noise_out, e.o);
            end
         end
      end
   end

   initial begin : driver
      logic [CH-1:0] en;
      int            per;
      logic [W-1:0]  seed;
      // Reset state.
      drive(1'b1, '0, 1'b0, '0, 0, 1'b0, 1'b0, '0, 0);
      drive(1'b1, '1, 1'b1, 3'd0, 5, 1'b1, 1'b1, 16'h1234, 0);
      // ch0 with P=0 steps every tick.
      idle(6'b000001, 2, 1);
      // Zero seed on ch1 loads as 1; full long-mode period.
      drive(1'b0, '0, 1'b1, 3'd1, 0, 1'b0, 1'b1, 16'h0000, 2);
      drive(1'b0, '0, 1'b1, 3'd2, 0, 1'b1, 1'b1, 16'h0001, 2);
      drive(1'b0, '0, 1'b1, 3'd3, 3, 1'b0, 1'b0, 16'hFFFF, 2);
      idle(6'b000010, 65535, 3);
      n_checks++;
      if (ch1_first_return != 65535) begin
         n_errors++;
         $display("FAIL model ch1 period: got %0d want 65535", ch1_first_return);
      end
      // Short mode on ch2.
      idle(6'b000100, 300, 4);
      // ch3 divider, then freeze for 5 ticks.
      idle(6'b001000, 20, 5);
      idle(6'b000000, 5, 5);
      idle(6'b001000, 12, 5);
      // Write to ch0 colliding with a due step, then out-of-range writes.
      idle(6'b000001, 1, 6);
      drive(1'b0, 6'b000001, 1'b1, 3'd0, 2, 1'b0, 1'b0, '0, 6);
      idle(6'b000001, 7, 6);
      drive(1'b0, '1, 1'b1, 3'd6, 9, 1'b1, 1'b1, 16'h1234, 7);
      drive(1'b0, '1, 1'b1, 3'd7, 1, 1'b1, 1'b1, 16'h0000, 7);
      idle('1, 10, 7);
      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         en   = CH'($urandom);
         per  = $urandom_range(0, 4);
         seed = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         drive($urandom_range(0, 99) == 0, en, $urandom_range(0, 9) == 0,
               CW'($urandom_range(0, 7)), per, 1'($urandom), 1'($urandom), seed, 8);
      end
      // Mixed config, then reset mid-run.
      drive(1'b0, '0, 1'b1, 3'd0, 1, 1'b1, 1'b1, 16'hACE1, 9);
      drive(1'b0, '0, 1'b1, 3'd4, 2, 1'b0, 1'b1, 16'h5A5A, 9);
      idle('1, 9, 9);
      drive(1'b1, '1, 1'b1, 3'd1, 3, 1'b1, 1'b1, 16'h0F0F, 10);
      idle('1, 4, 11);
      begin : drain
         int k;
         k = 0;
         while (sb.size() != 0 && k < 10) begin
            @(negedge audio_tick);
            k++;
         end
         #1;
         n_checks++;
         if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left want 0", sb.size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
